// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arb_pkg
//  Description : Shared types and helpers for the adder arbiter slice.
//                - state_e : result-register occupancy (EMPTY / FULL)
//                - id_w(n) : width of a requester index, never less than 1
//  Revision    : 1.0  initial release
// ============================================================================
package adder_arb_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches req upward from
//                ptr, wrapping N-1 -> 0, and grants the first set bit.
//  Ports       : req     [N]    request vector
//                ptr     [IDW]  search start index (always < N)
//                en             grant allowed this cycle
//                gnt     [N]    one-hot grant (all zero when en=0)
//                gnt_idx [IDW]  index of the granted bit (0 when none)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req,
    input  logic [id_w(N)-1:0]     ptr,
    input  logic                   en,
    output logic [N-1:0]           gnt,
    output logic [id_w(N)-1:0]     gnt_idx
);

    localparam int c_IDW = id_w(N);

    int               w_j;
    logic [c_IDW-1:0] w_jv;
    logic             w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_j     = 0;
        w_jv    = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate index (ptr + i) mod N; ptr < N so one subtract suffices.
            w_j = int'(ptr) + i;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            w_jv = c_IDW'(w_j);
            if (en && !w_found && req[w_jv]) begin
                gnt[w_jv] = 1'b1;
                gnt_idx   = w_jv;
                w_found   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter
//  Description : Shares one WIDTH-bit adder between NREQ requesters. Round-
//                robin grant, valid/ready on both sides, single-entry
//                registered result tagged with the requester index.
//  Ports       : clk, rst                synchronous active-high reset
//                req_valid/req_ready     per-requester handshake (one-hot)
//                req_a/req_b             packed operands, i at [i*W +: W]
//                resp_valid/resp_ready   result handshake
//                resp_id/resp_sum/resp_carry  registered result
//                resp_ovf                signed overflow (ADDER_ARB_OVF_EN)
//  Config      : define ADDER_ARB_OVF_EN to add the resp_ovf port/logic.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [id_w(NREQ)-1:0]     resp_id,
    output logic [WIDTH-1:0]          resp_sum,
    output logic                      resp_carry
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                      resp_ovf
`endif
);

    localparam int c_IDW = id_w(NREQ);

    state_e              state_q, state_d;
    logic [c_IDW-1:0]    ptr_q, ptr_d;
    logic [c_IDW-1:0]    id_q;
    logic [WIDTH-1:0]    sum_q;
    logic                carry_q;

    logic                w_can_accept;
    logic                w_accept;
    logic [NREQ-1:0]     w_gnt;
    logic [c_IDW-1:0]    w_gnt_idx;
    logic [WIDTH-1:0]    w_a_arr [NREQ];
    logic [WIDTH-1:0]    w_b_arr [NREQ];
    logic [WIDTH-1:0]    w_a_sel, w_b_sel;
    logic [WIDTH:0]      w_sum;

    // Register may be refilled in the same cycle it drains; reset blocks grants.
    assign w_can_accept = ((state_q == ST_EMPTY) || resp_ready) && !rst;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (w_can_accept),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_unpack
            assign w_a_arr[g] = req_a[g*WIDTH +: WIDTH];
            assign w_b_arr[g] = req_b[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_a_sel = w_a_arr[w_gnt_idx];
    assign w_b_sel = w_b_arr[w_gnt_idx];
    assign w_sum   = {1'b0, w_a_sel} + {1'b0, w_b_sel};

    // ---------------- FSM and round-robin pointer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (w_accept) begin
            state_d = ST_FULL;
            ptr_d   = (w_gnt_idx == c_IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end else if ((state_q == ST_FULL) && resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // ---------------- Result register ----------------
    // Loaded only on accept, so fields hold while stalled and after draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (w_accept) begin
            id_q    <= w_gnt_idx;
            sum_q   <= w_sum[WIDTH-1:0];
            carry_q <= w_sum[WIDTH];
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q;
    logic w_ovf;

    // Same-sign operands producing a result of the other sign.
    assign w_ovf = (w_a_sel[WIDTH-1] == w_b_sel[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != w_a_sel[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (w_accept) begin
            ovf_q <= w_ovf;
        end
    end

    assign resp_ovf = ovf_q;
`endif

    assign resp_valid = (state_q == ST_FULL);
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_carry = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_arbiter
//  Description : Self-checking bench for adder_arbiter. A transaction-level
//                model (grant search, arithmetic sum, occupancy flag) predicts
//                every output each cycle; directed scenarios are followed by a
//                randomized phase with random resets and backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WIDTH-1:0]  req_a;
    logic [NREQ*WIDTH-1:0]  req_b;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [IDW-1:0]         resp_id;
    logic [WIDTH-1:0]       resp_sum;
    logic                   resp_carry;
`ifdef ADDER_ARB_OVF_EN
    logic                   resp_ovf;
`endif

    adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_carry (resp_carry)
`ifdef ADDER_ARB_OVF_EN
        ,
        .resp_ovf   (resp_ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (reset values).
    bit               m_valid = 1'b0;
    int               m_id    = 0;
    logic [WIDTH-1:0] m_sum   = '0;
    bit               m_carry = 1'b0;
    bit               m_ovf   = 1'b0;
    int               m_ptr   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (rst || (m_valid && !resp_ready)) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int               g;
        logic [NREQ-1:0]  eg;
        logic [WIDTH-1:0] a, b;
        longint unsigned  s;
        @(negedge clk);
        g  = exp_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        check("req_ready",  req_ready,  eg);
        check("resp_valid", resp_valid, m_valid);
        check("resp_id",    resp_id,    m_id);
        check("resp_sum",   resp_sum,   m_sum);
        check("resp_carry", resp_carry, m_carry);
`ifdef ADDER_ARB_OVF_EN
        check("resp_ovf",   resp_ovf,   m_ovf);
`endif
        a = req_a[g*WIDTH +: WIDTH];
        b = req_b[g*WIDTH +: WIDTH];
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_id = 0; m_sum = '0; m_carry = 0; m_ovf = 0; m_ptr = 0;
        end else if (g >= 0) begin
            s       = longint'(a) + longint'(b);
            m_valid = 1;
            m_id    = g;
            m_sum   = s[WIDTH-1:0];
            m_carry = s[WIDTH];
            // Signed overflow from true signed arithmetic.
            m_ovf   = ((longint'($signed(a)) + longint'($signed(b))) > 64'sh7FFF_FFFF) ||
                      ((longint'($signed(a)) + longint'($signed(b))) < -64'sh8000_0000);
            m_ptr   = (g + 1) % NREQ;
        end else if (m_valid && resp_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        req_a      = '0;
        req_b      = '0;

        // 1. Reset with all requesters valid.
        cycle();
        cycle();
        rst = 1'b0;
        req_valid = '0;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_sum",   resp_sum,   '0);

        // 2. Single request from requester 2.
        req_valid = 4'b0100;
        set_ops(2, 32'h5, 32'h3);
        cycle();
        req_valid = '0;
        check("single_valid", resp_valid, 1'b1);
        check("single_id",    resp_id,    2);
        check("single_sum",   resp_sum,   32'h8);
        check("single_carry", resp_carry, 1'b0);
        cycle();

        // 3. Wrap / carry / overflow.
        req_valid = 4'b0001;
        set_ops(0, 32'hFFFF_FFFF, 32'h1);
        cycle();
        check("wrap_sum",   resp_sum,   32'h0);
        check("wrap_carry", resp_carry, 1'b1);
`ifdef ADDER_ARB_OVF_EN
        check("wrap_ovf",   resp_ovf,   1'b0);
`endif
        set_ops(0, 32'h7FFF_FFFF, 32'h1);
        cycle();
        check("ovf_sum",   resp_sum,   32'h8000_0000);
        check("ovf_carry", resp_carry, 1'b0);
`ifdef ADDER_ARB_OVF_EN
        check("ovf_ovf",   resp_ovf,   1'b1);
`endif
        req_valid = '0;
        cycle();

        // 4. Round robin from a fresh pointer.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i * 16), 32'(i));
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_valid", resp_valid, 1'b1);
            check("rr_id",    resp_id,    k % NREQ);
        end
        req_valid = '0;
        cycle();

        // 5. Backpressure on result 0x1234 from requester 1.
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        set_ops(1, 32'h1200, 32'h34);
        cycle();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_ready", req_ready,  '0);
            check("bp_sum",   resp_sum,   32'h1234);
            check("bp_id",    resp_id,    1);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_refill_ready", req_ready, 4'b0100);
        cycle();
        check("bp_refill_id", resp_id, 2);

        // 6. Reset during a stall.
        resp_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = '0;
        check("rst_stall_valid", resp_valid, 1'b0);
        check("rst_stall_sum",   resp_sum,   '0);
        resp_ready = 1'b1;
        req_valid  = '1;
        cycle();
        check("rst_stall_ptr", resp_id, 0);

        // Randomized phase.
        for (int n = 0; n < 2000; n++) begin
            req_valid  = NREQ'($urandom);
            resp_ready = ($urandom % 4) != 0;
            rst        = ($urandom % 64) == 0;
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom % 4)
                    0:       set_ops(i, 32'hFFFF_FFFF, $urandom);
                    1:       set_ops(i, 32'h7FFF_FFFF, 32'($urandom % 3));
                    default: set_ops(i, $urandom, $urandom);
                endcase
            end
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
